// File: rtl/serial_adder.sv
// Bit-serial N-bit adder: parallel operands are shifted LSB-first through a
// full-adder slice built from two half_adder cells, one bit per clock.

module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

module serial_adder #(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] sum,
  output logic         co
);
  localparam int unsigned CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  ra_q, ra_d;
  logic [N-1:0]  rb_q, rb_d;
  logic [N-1:0]  rs_q, rs_d;
  logic [N-1:0]  sum_q, sum_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          c_q, c_d;
  logic          co_q, co_d;

  logic p, g0, s, g1, cout;

  // Full-adder slice: propagate/generate from the operand bits, then fold in carry.
  half_adder u_ha0 (.a(ra_q[0]), .b(rb_q[0]), .s(p), .c(g0));
  half_adder u_ha1 (.a(p),       .b(c_q),     .s(s), .c(g1));
  assign cout = g0 | g1;

  always_comb begin
    state_d = state_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    rs_d    = rs_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    co_d    = co_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          ra_d    = a;
          rb_d    = b;
          rs_d    = '0;
          cnt_d   = '0;
          c_d     = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        rs_d  = {s, rs_q[N-1:1]};
        ra_d  = {1'b0, ra_q[N-1:1]};
        rb_d  = {1'b0, rb_q[N-1:1]};
        c_d   = cout;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          sum_d   = {s, rs_q[N-1:1]};
          co_d    = cout;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ra_q    <= '0;
      rb_q    <= '0;
      rs_q    <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      co_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      rs_q    <= rs_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      co_q    <= co_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign co   = co_q;
endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed scenarios on N=8 plus random
// pairs on N=8 and N=16, checked against plain a+b arithmetic.

module tb_serial_adder;
  logic        clk = 1'b0;
  logic        rst;
  logic        start8, start16;
  logic [7:0]  a8, b8, sum8;
  logic [15:0] a16, b16, sum16;
  logic        busy8, done8, co8;
  logic        busy16, done16, co16;

  int checks = 0;
  int errors = 0;
  logic [8:0] prev_res;

  always #5 clk = ~clk;

  serial_adder #(.N(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .sum(sum8), .co(co8)
  );

  serial_adder #(.N(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .sum(sum16), .co(co16)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One N=8 addition; start is re-pulsed (with junk operands) in RUN cycles flagged by mask.
  task automatic add8(input logic [7:0] x, input logic [7:0] y, input logic [7:0] mask);
    logic [8:0] e;
    e = {1'b0, x} + {1'b0, y};
    a8 = x; b8 = y; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom);
    for (int i = 0; i < 8; i++) begin
      check("run_busy", 64'(busy8), 64'(1));
      check("run_done", 64'(done8), 64'(0));
      check("run_hold", 64'({co8, sum8}), 64'(prev_res));
      if (mask[i]) begin
        start8 = 1'b1; a8 = 8'd1; b8 = 8'd1;
      end else begin
        start8 = 1'b0;
      end
      tick();
    end
    start8 = 1'b0;
    check("done_pulse", 64'(done8), 64'(1));
    check("done_busy", 64'(busy8), 64'(0));
    check("result", 64'({co8, sum8}), 64'(e));
    prev_res = e;
    tick();
    check("idle_done", 64'(done8), 64'(0));
    check("idle_busy", 64'(busy8), 64'(0));
    tick();
    check("no_rerun", 64'(busy8), 64'(0));
    check("idle_hold", 64'({co8, sum8}), 64'(e));
  endtask

  // Concurrent additions on both widths, bounded wait for each done.
  task automatic add_both(input logic [7:0] x8, input logic [7:0] y8,
                          input logic [15:0] x16, input logic [15:0] y16);
    logic [8:0]  e8;
    logic [16:0] e16;
    bit seen8, seen16;
    e8  = {1'b0, x8} + {1'b0, y8};
    e16 = {1'b0, x16} + {1'b0, y16};
    seen8 = 0; seen16 = 0;
    a8 = x8; b8 = y8; a16 = x16; b16 = y16;
    start8 = 1'b1; start16 = 1'b1;
    tick();
    start8 = 1'b0; start16 = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (done8 && !seen8) begin
        seen8 = 1;
        check("rnd_lat8", 64'(c + 1), 64'(8));
        check("rnd_sum8", 64'({co8, sum8}), 64'(e8));
      end
      if (done16 && !seen16) begin
        seen16 = 1;
        check("rnd_lat16", 64'(c + 1), 64'(16));
        check("rnd_sum16", 64'({co16, sum16}), 64'(e16));
      end
    end
    check("rnd_seen8", 64'(seen8), 64'(1));
    check("rnd_seen16", 64'(seen16), 64'(1));
    prev_res = e8;
  endtask

  initial begin
    rst = 1'b1; start8 = 1'b0; start16 = 1'b0;
    a8 = '0; b8 = '0; a16 = '0; b16 = '0;
    prev_res = '0;
    tick();
    tick();
    check("rst_busy8", 64'(busy8), 64'(0));
    check("rst_done8", 64'(done8), 64'(0));
    check("rst_res8", 64'({co8, sum8}), 64'(0));
    check("rst_busy16", 64'(busy16), 64'(0));
    check("rst_res16", 64'({co16, sum16}), 64'(0));
    rst = 1'b0;
    tick();

    add8(8'd3, 8'd5, 8'h00);
    add8(8'd255, 8'd1, 8'h00);
    add8(8'd200, 8'd100, 8'h00);
    add8(8'd0, 8'd0, 8'h00);
    add8(8'd10, 8'd20, 8'b0001_0100);

    // Reset in the fourth RUN cycle discards the run and clears the result.
    a8 = 8'd100; b8 = 8'd100; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_busy", 64'(busy8), 64'(0));
    check("mid_rst_done", 64'(done8), 64'(0));
    check("mid_rst_res", 64'({co8, sum8}), 64'(0));
    prev_res = '0;
    for (int i = 0; i < 12; i++) begin
      check("mid_rst_nodone", 64'(done8), 64'(0));
      tick();
    end

    // start held high: one result every N+2 cycles, sum held between DONE edges.
    a8 = 8'd1; b8 = 8'd2; start8 = 1'b1;
    tick();
    for (int t = 0; t < 30; t++) begin
      check("b2b_done", 64'(done8), 64'((t % 10) == 8));
      check("b2b_busy", 64'(busy8), 64'((t % 10) < 8));
      check("b2b_sum", 64'({co8, sum8}), (t >= 8) ? 64'(3) : 64'(0));
      tick();
    end
    start8 = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    prev_res = 9'd3;

    add_both(8'd255, 8'd1, 16'hFFFF, 16'h0001);
    for (int k = 0; k < 1000; k++)
      add_both(8'($urandom), 8'($urandom), 16'($urandom), 16'($urandom));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
